// File: rtl/matvec_pkg.sv
// Shared types and sizing constants for the 4x4 matrix-vector host block.
package matvec_pkg;

    // Host sequencing states; the encoding is fixed at 3 bits so that unused
    // codes exist and can be detected as illegal.
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERROR = 3'd4
    } host_state_t;

    localparam int MAT_ELEMS  = 16;
    localparam int VEC_ELEMS  = 4;
    localparam int LOAD_WORDS = MAT_ELEMS + VEC_ELEMS;
    localparam int RES_WORDS  = 4;

endpackage

// File: rtl/matvec_result_serializer.sv
// Captures the four accelerator products in one cycle and replays them as a
// 4-word valid/ready stream, flagging the final word with m_last.
module matvec_result_serializer
    import matvec_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [RES_WORDS*W-1:0] prod,
    output logic [W-1:0]           m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   done_last
);

    logic [W-1:0] res_q [RES_WORDS];
    logic [1:0]   idx_q;
    logic         full_q;
    logic         xfer;
    logic         at_last;

    assign xfer    = full_q && m_ready;
    assign at_last = (idx_q == 2'(RES_WORDS - 1));

    // Capture products on load; step the index on each accepted word and
    // release the stream after the final word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RES_WORDS; i++) res_q[i] <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < RES_WORDS; i++) res_q[i] <= prod[i*W +: W];
            idx_q  <= '0;
            full_q <= 1'b1;
        end else if (xfer) begin
            if (at_last) begin
                idx_q  <= '0;
                full_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // Output word is driven only while the stream is active so idle m_data is 0.
    always_comb begin
        m_valid   = full_q;
        m_data    = full_q ? res_q[idx_q] : '0;
        m_last    = full_q && at_last;
        done_last = xfer && at_last;
    end

endmodule

// File: rtl/matvec_seq_host.sv
// Host sequencer for the sequential 4x4 matrix-vector accelerator: gathers 20
// operand words, issues one job, waits for the products with a timeout, then
// streams the four results downstream.
//
// Handshakes: every interface (s_*, acc_valid/acc_ready, acc_done/acc_take,
// m_*) transfers exactly in a cycle where its valid and ready are both high at
// the rising clk edge; a valid, once raised, holds its data stable until that
// transfer happens.
module matvec_seq_host
    import matvec_pkg::*;
#(
    parameter int W       = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [MAT_ELEMS*W-1:0] acc_mat,
    output logic [VEC_ELEMS*W-1:0] acc_vec,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    input  logic [RES_WORDS*W-1:0] acc_prod,
    input  logic                   acc_done,
    output logic                   acc_take,
    output logic [W-1:0]           m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   err
);

    localparam logic [2:0] ST_LOAD  = S_LOAD;
    localparam logic [2:0] ST_ISSUE = S_ISSUE;
    localparam logic [2:0] ST_WAIT  = S_WAIT;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_ERROR = S_ERROR;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [4:0]    load_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [W-1:0]  mat_q [MAT_ELEMS];
    logic [W-1:0]  vec_q [VEC_ELEMS];

    logic load_xfer;
    logic last_word;
    logic to_expired;
    logic capture;
    logic done_last;

    // s_ready is forced low while rst is asserted, even though the state is
    // already LOAD during reset.
    assign s_ready    = (state_q == ST_LOAD) && !rst;
    assign load_xfer  = s_valid && s_ready;
    assign last_word  = (load_cnt_q == 5'(LOAD_WORDS - 1));
    assign to_expired = (to_cnt_q == TW'(TIMEOUT - 1));
    assign capture    = (state_q == ST_WAIT) && acc_done;

    // Next-state selection; acc_done takes priority over an expiring timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (load_xfer && last_word) state_d = ST_ISSUE;
            ST_ISSUE: if (acc_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                if (acc_done)        state_d = ST_DRAIN;
                else if (to_expired) state_d = ST_ERROR;
            end
            ST_DRAIN: if (done_last) state_d = ST_LOAD;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // State register plus the load counter and the wait-timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD && load_xfer) begin
                load_cnt_q <= last_word ? 5'd0 : load_cnt_q + 5'd1;
            end
            if (state_q == ST_ISSUE) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_WAIT && !acc_done && !to_expired) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    // Operand slots are written only by accepted upstream words, which can
    // only happen in LOAD, so they stay stable through ISSUE and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAT_ELEMS; i++) mat_q[i] <= '0;
            for (int i = 0; i < VEC_ELEMS; i++) vec_q[i] <= '0;
        end else if (load_xfer) begin
            if (load_cnt_q[4]) vec_q[load_cnt_q[1:0]] <= s_data;
            else               mat_q[load_cnt_q[3:0]] <= s_data;
        end
    end

    // Flatten operand slots onto the accelerator buses.
    always_comb begin
        acc_mat = '0;
        acc_vec = '0;
        for (int i = 0; i < MAT_ELEMS; i++) acc_mat[i*W +: W] = mat_q[i];
        for (int i = 0; i < VEC_ELEMS; i++) acc_vec[i*W +: W] = vec_q[i];
    end

    // Per-state control outputs.
    always_comb begin
        acc_valid = (state_q == ST_ISSUE);
        acc_take  = (state_q == ST_WAIT);
        err       = (state_q == ST_ERROR);
        busy      = !((state_q == ST_LOAD) && (load_cnt_q == 5'd0));
    end

    matvec_result_serializer #(.W(W)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .prod      (acc_prod),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .done_last (done_last)
    );

endmodule

// File: tb/tb_matvec_seq_host.sv
// Directed bench for matvec_seq_host. Two hosts run in lockstep on the same
// stream: one with TIMEOUT=64 and one with TIMEOUT=17, where acc_done lands on
// the very cycle the short timeout would expire. Each host has its own
// behavioural accelerator (16 compute cycles, then one done cycle).
module tb_matvec_seq_host;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] s_data;
  logic s_valid;
  logic m_ready;
  logic never_done;

  logic          s_ready   [2];
  logic [1023:0] acc_mat   [2];
  logic [255:0]  acc_vec   [2];
  logic          acc_valid [2];
  logic          acc_ready [2];
  logic [255:0]  acc_prod  [2];
  logic          acc_done  [2];
  logic          acc_take  [2];
  logic [63:0]   m_data    [2];
  logic          m_valid   [2];
  logic          m_last    [2];
  logic          busy      [2];
  logic          err       [2];

  logic        mbusy [2];
  int          mcnt  [2];
  logic [63:0] words [20];
  logic [63:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int av_cnt = 0;
  int viol   = 0;

  always #5 clk = ~clk;

  matvec_seq_host #(.W(64), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[0]),
    .acc_mat(acc_mat[0]), .acc_vec(acc_vec[0]), .acc_valid(acc_valid[0]), .acc_ready(acc_ready[0]),
    .acc_prod(acc_prod[0]), .acc_done(acc_done[0]), .acc_take(acc_take[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_last(m_last[0]),
    .busy(busy[0]), .err(err[0])
  );

  matvec_seq_host #(.W(64), .TIMEOUT(17)) u_dut17 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[1]),
    .acc_mat(acc_mat[1]), .acc_vec(acc_vec[1]), .acc_valid(acc_valid[1]), .acc_ready(acc_ready[1]),
    .acc_prod(acc_prod[1]), .acc_done(acc_done[1]), .acc_take(acc_take[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_last(m_last[1]),
    .busy(busy[1]), .err(err[1])
  );

  function automatic logic [255:0] matvec(input logic [1023:0] m, input logic [255:0] v);
    logic [255:0] r;
    real acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 0.0;
      for (int j = 0; j < 4; j++)
        acc = acc + $bitstoreal(m[(i*4+j)*64 +: 64]) * $bitstoreal(v[j*64 +: 64]);
      r[i*64 +: 64] = $realtobits(acc);
    end
    return r;
  endfunction

  // Behavioural accelerators: idle -> 16 compute cycles -> 1 done cycle.
  for (genvar g = 0; g < 2; g++) begin : g_acc
    assign acc_ready[g] = !mbusy[g];
    assign acc_done[g]  = mbusy[g] && (mcnt[g] == 16) && !never_done;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mbusy[g]    <= 1'b0;
        mcnt[g]     <= 0;
        acc_prod[g] <= '0;
      end else if (!mbusy[g]) begin
        if (acc_valid[g]) begin
          mbusy[g]    <= 1'b1;
          mcnt[g]     <= 0;
          acc_prod[g] <= matvec(acc_mat[g], acc_vec[g]);
        end
      end else if (acc_done[g]) begin
        if (acc_take[g]) begin
          mbusy[g]    <= 1'b0;
          acc_prod[g] <= '0;
        end
      end else begin
        mcnt[g] <= mcnt[g] + 1;
      end
    end
  end

  // Cycle monitors: issue-pulse count and s_ready overlap with later phases.
  always @(negedge clk) begin
    if (acc_valid[0]) av_cnt <= av_cnt + 1;
    if (s_ready[0] && (acc_valid[0] || acc_take[0] || m_valid[0])) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] rb(input real r);
    return $realtobits(r);
  endfunction

  // Send one word; returns 1 ns after the accepting edge.
  task automatic send(input logic [63:0] d);
    int guard;
    @(negedge clk);
    s_data = d;
    s_valid = 1'b1;
    guard = 0;
    while (!s_ready[0] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk1("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      send(words[i]);
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic fill_diag(input real d, input real v0, input real v1, input real v2, input real v3);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        words[r*4+c] = (r == c) ? rb(d) : 64'd0;
    words[16] = rb(v0); words[17] = rb(v1); words[18] = rb(v2); words[19] = rb(v3);
  endtask

  task automatic fill_rows1234();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        words[r*4+c] = rb(real'(c + 1));
    for (int i = 16; i < 20; i++) words[i] = rb(1.0);
  endtask

  // Collect four results from both hosts, optionally stalling at one index.
  task automatic collect(input int stall_at, input int stall_n);
    int got;
    int waited;
    bit stalled;
    logic [63:0] e;
    got = 0;
    waited = 0;
    stalled = 0;
    m_ready = 1'b1;
    while (got < 4 && waited < 300) begin
      @(negedge clk);
      waited++;
      if (m_valid[0] && got == stall_at && !stalled) begin
        stalled = 1;
        m_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          chk1("stall_valid", m_valid[0], 1'b1);
          chk("stall_data", m_data[0], exp_q[0]);
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
      if (m_valid[0]) begin
        e = exp_q.pop_front();
        chk("m_data", m_data[0], e);
        chk1("m_last", m_last[0], got == 3);
        chk("m_data_t17", m_data[1], e);
        got++;
      end
    end
    if (got < 4) chk1("collect_timeout", 1'b0, 1'b1);
    @(negedge clk);
    chk1("post_drain_m_valid", m_valid[0], 1'b0);
    chk1("post_drain_s_ready", s_ready[0], 1'b1);
    chk1("post_drain_busy", busy[0], 1'b0);
  endtask

  initial begin
    int av0;
    rst = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    never_done = 1'b0;

    // Reset values
    #12;
    chk1("rst_s_ready", s_ready[0], 1'b0);
    chk1("rst_acc_valid", acc_valid[0], 1'b0);
    chk1("rst_acc_take", acc_take[0], 1'b0);
    chk1("rst_m_valid", m_valid[0], 1'b0);
    chk1("rst_m_last", m_last[0], 1'b0);
    chk("rst_m_data", m_data[0], 64'd0);
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_err", err[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("idle_s_ready", s_ready[0], 1'b1);

    // Identity x {1,2,3,4}; single issue pulse; issue the cycle after word 19
    fill_diag(1.0, 1.0, 2.0, 3.0, 4.0);
    exp_q = {rb(1.0), rb(2.0), rb(3.0), rb(4.0)};
    av0 = av_cnt;
    send_range(0, 19, 0);
    chk1("issue_latency", acc_valid[0], 1'b1);
    chk1("s_ready_after_w19", s_ready[0], 1'b0);
    collect(-1, 0);
    chk("acc_valid_cycles", 64'(av_cnt - av0), 64'd1);

    // Rows {1,2,3,4} x ones with gaps on s_valid
    fill_rows1234();
    exp_q = {rb(10.0), rb(10.0), rb(10.0), rb(10.0)};
    send_range(0, 19, 1);
    chk("slot5", acc_mat[0][5*64 +: 64], rb(2.0));
    chk("vec3", acc_vec[0][3*64 +: 64], rb(1.0));
    collect(-1, 0);

    // Downstream stall of 5 cycles at result index 2
    fill_diag(2.0, 1.0, 2.0, 3.0, 4.0);
    exp_q = {rb(2.0), rb(4.0), rb(6.0), rb(8.0)};
    send_range(0, 19, 0);
    collect(2, 5);
    chk("s_ready_overlap", 64'(viol), 64'd0);

    // Accelerator never completes: error exactly TIMEOUT cycles into WAIT
    never_done = 1'b1;
    fill_diag(1.0, 1.0, 1.0, 1.0, 1.0);
    send_range(0, 19, 0);
    @(posedge clk);
    #1;
    chk1("wait_entered", acc_take[0], 1'b1);
    repeat (63) @(posedge clk);
    #1;
    chk1("err_before_timeout", err[0], 1'b0);
    @(posedge clk);
    #1;
    chk1("err_at_timeout", err[0], 1'b1);
    chk1("err_s_ready", s_ready[0], 1'b0);
    chk1("err_acc_take", acc_take[0], 1'b0);
    chk1("err_t17", err[1], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk1("err_sticky", err[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("err_cleared", err[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    never_done = 1'b0;
    #1;
    chk1("s_ready_restored", s_ready[0], 1'b1);

    // Asynchronous reset mid-load, then a fresh load
    fill_diag(1.0, 9.0, 9.0, 9.0, 9.0);
    send_range(0, 9, 0);
    chk1("busy_midload", busy[0], 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk1("async_busy", busy[0], 1'b0);
    chk1("async_s_ready", s_ready[0], 1'b0);
    chk("async_slot0", acc_mat[0][63:0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_diag(1.0, 5.0, 6.0, 7.0, 8.0);
    exp_q = {rb(5.0), rb(6.0), rb(7.0), rb(8.0)};
    send_range(0, 19, 0);
    collect(-1, 0);

    // Back-to-back jobs, second with a zero matrix
    fill_rows1234();
    exp_q = {rb(10.0), rb(10.0), rb(10.0), rb(10.0)};
    send_range(0, 19, 0);
    collect(-1, 0);
    fill_diag(0.0, 1.0, 2.0, 3.0, 4.0);
    exp_q = {64'd0, 64'd0, 64'd0, 64'd0};
    send_range(0, 19, 0);
    collect(-1, 0);
    chk1("t17_no_err", err[1], 1'b0);
    chk1("t64_no_err", err[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
